// File: rtl/tpu_core.sv
// tpu_core: tiled C = A x B on a 4x4 multiply-accumulate array.
// Define TPU_SIGNED_EN for signed 8-bit operands; default is unsigned.
module tpu_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   K,
  input  logic [7:0]   M,
  input  logic [7:0]   N,
  output logic         busy,
  output logic         A_wr_en,
  output logic         B_wr_en,
  output logic [15:0]  A_index,
  output logic [15:0]  B_index,
  output logic [31:0]  A_data_in,
  output logic [31:0]  B_data_in,
  input  logic [31:0]  A_data_out,
  input  logic [31:0]  B_data_out,
  output logic         C_wr_en,
  output logic [15:0]  C_index,
  output logic [127:0] C_data_in,
  input  logic [127:0] C_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]  k_len, m_len, n_len;
  logic [7:0]  k_cnt, m_base;
  logic [8:0]  mb, nb, mb_num, nb_num;
  logic [15:0] a_base, b_base, c_base;
  logic [1:0]  r_cnt;
  logic        v1;
  logic [31:0] acc [4][4];
  logic        zero_dim, k_last, row_last;
  logic        nb_last, tile_last;
  logic        unused_c;

  function automatic logic [31:0] mul8(
    input logic [7:0] a,
    input logic [7:0] b
  );
`ifdef TPU_SIGNED_EN
    mul8 = {{24{a[7]}}, a} * {{24{b[7]}}, b};
`else
    mul8 = {24'd0, a} * {24'd0, b};
`endif
  endfunction

  assign A_wr_en   = 1'b0;
  assign B_wr_en   = 1'b0;
  assign A_data_in = 32'd0;
  assign B_data_in = 32'd0;
  assign unused_c  = ^C_data_out;

  assign busy    = (state != S_IDLE);
  assign A_index = a_base + {8'd0, k_cnt};
  assign B_index = b_base + {8'd0, k_cnt};

  assign mb_num    = ({1'b0, m_len} + 9'd3) >> 2;
  assign nb_num    = ({1'b0, n_len} + 9'd3) >> 2;
  assign zero_dim  = (K == 8'd0) || (M == 8'd0) || (N == 8'd0);
  assign k_last    = (k_cnt == k_len - 8'd1);
  assign nb_last   = (nb == nb_num - 9'd1);
  assign tile_last = nb_last && (mb == mb_num - 9'd1);
  assign row_last  = (r_cnt == 2'd3) ||
    ({1'b0, m_base} + {7'd0, r_cnt} + 9'd1 == {1'b0, m_len});

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (in_valid)
          state_n = zero_dim ? S_DONE : S_COMPUTE;
      S_COMPUTE:
        if (k_last)
          state_n = S_DRAIN;
      S_DRAIN:
        state_n = S_WRITE;
      S_WRITE:
        if (row_last)
          state_n = tile_last ? S_DONE : S_COMPUTE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= S_IDLE;
      v1        <= 1'b0;
      k_len     <= 8'd0;
      m_len     <= 8'd0;
      n_len     <= 8'd0;
      k_cnt     <= 8'd0;
      m_base    <= 8'd0;
      mb        <= 9'd0;
      nb        <= 9'd0;
      a_base    <= 16'd0;
      b_base    <= 16'd0;
      c_base    <= 16'd0;
      r_cnt     <= 2'd0;
      C_wr_en   <= 1'b0;
      C_index   <= 16'd0;
      C_data_in <= 128'd0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          acc[i][j] <= 32'd0;
    end else begin
      state   <= state_n;
      v1      <= (state == S_COMPUTE);
      C_wr_en <= 1'b0;

      // Read data lags the index by one cycle, so accumulate on v1.
      if (v1)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            acc[i][j] <= acc[i][j] + mul8(
              A_data_out[31-8*i -: 8],
              B_data_out[31-8*j -: 8]);

      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            k_len  <= K;
            m_len  <= M;
            n_len  <= N;
            k_cnt  <= 8'd0;
            r_cnt  <= 2'd0;
            m_base <= 8'd0;
            mb     <= 9'd0;
            nb     <= 9'd0;
            a_base <= 16'd0;
            b_base <= 16'd0;
            c_base <= 16'd0;
            for (int i = 0; i < 4; i++)
              for (int j = 0; j < 4; j++)
                acc[i][j] <= 32'd0;
          end
        end
        S_COMPUTE:
          k_cnt <= k_cnt + 8'd1;
        S_WRITE: begin
          C_wr_en   <= 1'b1;
          C_index   <= c_base + {8'd0, m_base} + {14'd0, r_cnt};
          C_data_in <= {acc[r_cnt][0], acc[r_cnt][1],
                        acc[r_cnt][2], acc[r_cnt][3]};
          r_cnt     <= r_cnt + 2'd1;
          if (row_last) begin
            r_cnt <= 2'd0;
            k_cnt <= 8'd0;
            for (int i = 0; i < 4; i++)
              for (int j = 0; j < 4; j++)
                acc[i][j] <= 32'd0;
            if (nb_last) begin
              nb     <= 9'd0;
              b_base <= 16'd0;
              c_base <= 16'd0;
              mb     <= mb + 9'd1;
              a_base <= a_base + {8'd0, k_len};
              m_base <= m_base + 8'd4;
            end else begin
              nb     <= nb + 9'd1;
              b_base <= b_base + {8'd0, k_len};
              c_base <= c_base + {8'd0, m_len};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_core.sv
// tb_tpu_core: directed job table plus restart/abort sequences for tpu_core.
// Expected C words are hand-computed per job.
module tb_tpu_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   k_in, m_in, n_in;
  logic         busy;
  logic         A_wr_en, B_wr_en;
  logic [15:0]  A_index, B_index;
  logic [31:0]  A_data_in, B_data_in;
  logic [31:0]  a_rd, b_rd;
  logic         C_wr_en;
  logic [15:0]  C_index;
  logic [127:0] C_data_in;

  logic [31:0] amem [65536];
  logic [31:0] bmem [65536];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0]  cap_idx [$];
  logic [127:0] cap_dat [$];
  int           cap_cyc [$];

  typedef struct {
    logic [15:0]  idx;
    logic [127:0] data;
  } wr_t;

  typedef struct {
    int         mode;
    logic [7:0] k;
    logic [7:0] m;
    logic [7:0] n;
    int         nwr;
    int         off;
  } job_t;

  wr_t  ew [19];
  job_t jobs [5];

  tpu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .K          (k_in),
    .M          (m_in),
    .N          (n_in),
    .busy       (busy),
    .A_wr_en    (A_wr_en),
    .B_wr_en    (B_wr_en),
    .A_index    (A_index),
    .B_index    (B_index),
    .A_data_in  (A_data_in),
    .B_data_in  (B_data_in),
    .A_data_out (a_rd),
    .B_data_out (b_rd),
    .C_wr_en    (C_wr_en),
    .C_index    (C_index),
    .C_data_in  (C_data_in),
    .C_data_out (128'd0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    a_rd <= amem[A_index];
    b_rd <= bmem[B_index];
  end

  always @(negedge clk)
    if (C_wr_en) begin
      cap_idx.push_back(C_index);
      cap_dat.push_back(C_data_in);
      cap_cyc.push_back(cyc);
    end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 65536; i++) begin
      amem[i] = 32'd0;
      bmem[i] = 32'd0;
    end
    case (mode)
      0: begin
        amem[0] = 32'h01000000; amem[1] = 32'h00010000;
        amem[2] = 32'h00000100; amem[3] = 32'h00000001;
        bmem[0] = 32'h01020304; bmem[1] = 32'h05060708;
        bmem[2] = 32'h090A0B0C; bmem[3] = 32'h0D0E0F10;
      end
      1: for (int i = 0; i < 3; i++) begin
        amem[i]   = 32'h01010101;
        amem[3+i] = 32'h01000000;
        bmem[i]   = 32'h01010101;
        bmem[3+i] = 32'h01010000;
      end
      2: begin
        amem[0] = 32'h80000000;
        bmem[0] = 32'h7F000000;
      end
      3: for (int i = 0; i < 255; i++) begin
        amem[i] = 32'h7F7F7F7F;
        bmem[i] = 32'h7F7F7F7F;
      end
      default: ;
    endcase
  endtask

  task automatic clear_cap();
    cap_idx.delete();
    cap_dat.delete();
    cap_cyc.delete();
  endtask

  task automatic start(input logic [7:0] k, input logic [7:0] m,
                       input logic [7:0] n, output int s);
    @(negedge clk);
    in_valid = 1'b1;
    k_in = k;
    m_in = m;
    n_in = n;
    @(negedge clk);
    s = cyc;
    in_valid = 1'b0;
    chk("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_idle(input int budget, output int f);
    bit ok;
    ok = 1'b0;
    f = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        f = cyc;
        break;
      end
    end
    chk("done_in_budget", ok, 1'b1);
  endtask

  task automatic check_writes(input string name, input int nwr,
                              input int off);
    chk({name, "_count"}, cap_idx.size(), nwr);
    for (int w = 0; w < nwr; w++)
      if (w < cap_idx.size()) begin
        chk({name, "_idx"}, cap_idx[w], ew[off+w].idx);
        chk({name, "_data"}, cap_dat[w], ew[off+w].data);
      end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] r3, r3p, r7f;
    int s, f, bound, mbn, nbn;

    r3  = {32'd3, 32'd3, 32'd3, 32'd3};
    r3p = {32'd3, 32'd3, 32'd0, 32'd0};
    r7f = {4{32'h003EC1FF}};

    ew[0] = '{16'd0, {32'd1,  32'd2,  32'd3,  32'd4}};
    ew[1] = '{16'd1, {32'd5,  32'd6,  32'd7,  32'd8}};
    ew[2] = '{16'd2, {32'd9,  32'd10, 32'd11, 32'd12}};
    ew[3] = '{16'd3, {32'd13, 32'd14, 32'd15, 32'd16}};
    ew[4]  = '{16'd0, r3};
    ew[5]  = '{16'd1, r3};
    ew[6]  = '{16'd2, r3};
    ew[7]  = '{16'd3, r3};
    ew[8]  = '{16'd5, r3p};
    ew[9]  = '{16'd6, r3p};
    ew[10] = '{16'd7, r3p};
    ew[11] = '{16'd8, r3p};
    ew[12] = '{16'd4, r3};
    ew[13] = '{16'd9, r3p};
`ifdef TPU_SIGNED_EN
    ew[14] = '{16'd0, {32'hFFFFC080, 96'd0}};
`else
    ew[14] = '{16'd0, {32'd16256, 96'd0}};
`endif
    ew[15] = '{16'd0, r7f};
    ew[16] = '{16'd1, r7f};
    ew[17] = '{16'd2, r7f};
    ew[18] = '{16'd3, r7f};

    jobs[0] = '{0, 8'd4,   8'd4, 8'd4, 4,  0};
    jobs[1] = '{1, 8'd3,   8'd5, 8'd6, 10, 4};
    jobs[2] = '{2, 8'd1,   8'd1, 8'd1, 1,  14};
    jobs[3] = '{3, 8'd255, 8'd4, 8'd4, 4,  15};
    jobs[4] = '{4, 8'd0,   8'd4, 8'd4, 0,  0};

    rst_n = 1'b1;
    in_valid = 1'b0;
    k_in = 8'd0;
    m_in = 8'd0;
    n_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_c_wr_en", C_wr_en, 1'b0);
    chk("rst_a_index", A_index, 16'd0);
    chk("rst_b_index", B_index, 16'd0);
    chk("rst_c_index", C_index, 16'd0);
    chk("rst_c_data", C_data_in, 128'd0);
    chk("rst_ab_wr_en", {A_wr_en, B_wr_en}, 2'b00);
    chk("rst_ab_data", {A_data_in, B_data_in}, 64'd0);
    rst_n = 1'b0;

    for (int j = 0; j < 5; j++) begin
      fill(jobs[j].mode);
      clear_cap();
      start(jobs[j].k, jobs[j].m, jobs[j].n, s);
      wait_idle(2000, f);
      check_writes($sformatf("job%0d", j), jobs[j].nwr, jobs[j].off);
      if (jobs[j].nwr > 0) begin
        if (cap_cyc.size() > 0)
          chk("busy_fall", f, cap_cyc[cap_cyc.size()-1] + 1);
      end else begin
        chk("zero_pulse", f - s, 1);
      end
      mbn = (int'(jobs[j].m) + 3) / 4;
      nbn = (int'(jobs[j].n) + 3) / 4;
      bound = mbn * nbn * (int'(jobs[j].k) + 12) + 4;
      chk("latency_bound", (f - s + 1) <= bound, 1'b1);
    end

    fill(0);
    clear_cap();
    start(8'd4, 8'd4, 8'd4, s);
    @(negedge clk);
    in_valid = 1'b1;
    k_in = 8'd1;
    m_in = 8'd1;
    n_in = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    k_in = 8'd9;
    m_in = 8'd9;
    n_in = 8'd9;
    wait_idle(2000, f);
    check_writes("restart", 4, 0);
    repeat (5) @(negedge clk);
    chk("restart_no_rerun", cap_idx.size(), 4);

    fill(3);
    clear_cap();
    start(8'd255, 8'd4, 8'd4, s);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_c_wr_en", C_wr_en, 1'b0);
    repeat (300) @(negedge clk);
    chk("abort_no_writes", cap_idx.size(), 0);
    chk("abort_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_core.md
TPU_CORE -- requirements
Module: tpu_core

Interface
REQ-001 The block SHALL be one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be, as name, direction, width and meaning:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-high despite the name.
- in_valid  in  1  one-cycle start strobe; K, M, N sampled with it.
- K, M, N  in  8 each  A is MxK, B is KxN, C is MxN; each dimension 1..255.
- busy  out  1  high while a job is in progress.
- A_wr_en, B_wr_en  out  1 each  buffer write enables, tied 0.
- A_index, B_index  out  16 each  buffer read addresses.
- A_data_in, B_data_in  out  32 each  tied 0.
- A_data_out, B_data_out  in  32 each  buffer read data.
- C_wr_en  out  1  C buffer write strobe.
- C_index  out  16  C write address.
- C_data_in  out  128  C write data.
- C_data_out  in  128  unused.

Function
REQ-003 The block SHALL compute C = A x B with a 4x4 multiply-accumulate array, using 8-bit operands and 32-bit wrap-around accumulators.
REQ-004 A and B buffer reads SHALL have one-cycle latency: data for the index driven in cycle t is valid in cycle t+1.
REQ-005 Tile counts SHALL be MB = ceil(M/4) and NB = ceil(N/4).
REQ-006 A word layout:
- Address = mb*K + k.
- Byte lane i (bits 31-8i down to 24-8i) holds A[4mb+i][k].
- The producer zero-pads lanes with row >= M.
REQ-007 B word layout:
- Address = nb*K + k.
- Lane j (bits 31-8j down to 24-8j) holds B[k][4nb+j].
- The producer zero-pads lanes with column >= N.
REQ-008 C word layout:
- Address = nb*M + m.
- Lane j (bits 127-32j down to 96-32j) holds C[m][4nb+j].
- Lanes with column >= N SHALL be written as the computed value of the zero padding, i.e. 0.
- No C write SHALL occur for rows m >= M.
REQ-009 Tiles SHALL be processed mb-outer, nb-inner; each tile streams k = 0..K-1 and then writes its up to 4 valid rows, one per cycle.
REQ-010 State machine:
- IDLE: on in_valid, go to COMPUTE.
- COMPUTE: K reads plus array skew, then go to DRAIN.
- DRAIN: flush the array, then go to WRITE.
- WRITE: write the tile's rows; go to the next tile's COMPUTE, or to DONE after the last tile.
- DONE: go to IDLE after one cycle.
REQ-011 Accumulators SHALL clear at the start of every tile.
REQ-012 busy SHALL rise in the cycle after in_valid is sampled.
REQ-013 busy SHALL fall in the cycle after the last C write.
REQ-014 busy SHALL fall no later than MB*NB*(K+12)+4 cycles after in_valid.
REQ-015 in_valid SHALL be ignored while busy is high.
REQ-016 K, M and N SHALL be latched at start; input changes during a job SHALL have no effect.
REQ-017 If K, M or N is 0, busy SHALL pulse for exactly one cycle and no C write SHALL occur.
REQ-018 C_wr_en SHALL be high for exactly one cycle per written word; C_index and C_data_in SHALL be valid in that same cycle.

Reset
REQ-019 When rst_n is high at a clock edge, the block SHALL enter IDLE and clear all accumulators.
REQ-020 Outputs SHALL reset to 0: busy, C_wr_en, C_index, C_data_in, A_index, B_index.
REQ-021 Reset asserted mid-job SHALL abort the job within one cycle, with no further C writes.

Configuration
REQ-022 Macro TPU_SIGNED_EN:
- Defined: A and B bytes are two's-complement signed (-128..127), products are sign-extended before accumulation.
- Undefined: bytes are unsigned (0..255).

Verification
REQ-023 Reset: hold rst_n high for 3 cycles -> busy=0, C_wr_en=0 and all indices 0.
REQ-024 Single tile: K=M=N=4, A=identity, B[k][j]=k*4+j+1 -> C rows equal B; 4 writes at C_index 0..3; busy falls after the last write.
REQ-025 Padding: M=5, N=6, K=3, all A and B elements 1 -> MB=NB=2.
- 10 writes, addresses 0..4 and 5..9.
- Valid lanes = 3; padded lanes = 0.
REQ-026 Signed operands (TPU_SIGNED_EN defined): K=1, M=N=1, A=-128, B=127 -> C lane0 = 0xFFFF C080.
- Unsigned build with the same bytes: C lane0 = 128*127 = 16256.
REQ-027 Long K: K=255, M=N=4, all bytes 0x7F, unsigned build -> every valid lane = 255*127*127 = 4112895.
REQ-028 Restart and abort:
- in_valid pulsed while busy with different K -> ignored, results match the first job.
- rst_n high mid-job -> busy=0 the next cycle and no C writes thereafter.
